// File: rtl/dffram_wb_slave_pkg.sv
// Shared types for the DFFRAM Wishbone slave: FSM state encoding and RAM address sizing.
package dffram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RDATA,
    ACK,
    ERR
  } state_t;

  // Word-address width for a DFFRAM built from 256-word banks.
  function automatic int unsigned ram_a_width(input int unsigned wsize);
    return 8 + $clog2(wsize);
  endfunction

endpackage

// File: rtl/dffram_wb_slave_if.sv
// Wishbone classic bus bundle between the SoC interconnect (master) and a DFFRAM slave.
interface dffram_wb_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/dffram_wb_slave.sv
// Wishbone classic slave fronting one DFFRAM macro; converts single WB cycles into
// registered RAM strobes and returns registered read data with ack, or err on address miss.
module dffram_wb_slave
  import dffram_pkg::*;
#(
  parameter int unsigned   WSIZE     = 4,
  parameter logic [31:0]   BASE_ADDR = 32'h3000_0000,
  localparam int unsigned  A_WIDTH   = ram_a_width(WSIZE)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dffram_wb_slave_if.slave   wb,
  output logic               ram_en_o,
  output logic [3:0]         ram_we_o,
  output logic [A_WIDTH-1:0] ram_a_o,
  output logic [31:0]        ram_di_o,
  input  logic [31:0]        ram_do_i
);

  localparam int unsigned HI = A_WIDTH + 2;

  state_t             r_state, w_state_d;
  logic               r_ack, w_ack_d;
  logic               r_err, w_err_d;
  logic               r_en, w_en_d;
  logic [3:0]         r_we_strb, w_we_strb_d;
  logic [A_WIDTH-1:0] r_a, w_a_d;
  logic [31:0]        r_di, w_di_d;
  logic [31:0]        r_dat, w_dat_d;
  logic               r_wr, w_wr_d;

  logic w_req;
  logic w_hit;
  logic w_unused_adr;

  assign w_req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_hit        = (wb.wb_adr_i[31:HI] == BASE_ADDR[31:HI]);
  assign w_unused_adr = ^wb.wb_adr_i[1:0];

  always_comb begin
    w_state_d   = r_state;
    w_ack_d     = 1'b0;
    w_err_d     = 1'b0;
    w_en_d      = 1'b0;
    w_we_strb_d = '0;
    w_a_d       = r_a;
    w_di_d      = r_di;
    w_dat_d     = r_dat;
    w_wr_d      = r_wr;

    unique case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          w_state_d   = ISSUE;
          w_a_d       = wb.wb_adr_i[A_WIDTH+1:2];
          w_di_d      = wb.wb_dat_i;
          w_wr_d      = wb.wb_we_i;
          w_en_d      = 1'b1;
          w_we_strb_d = wb.wb_we_i ? wb.wb_sel_i : 4'b0000;
        end else if (w_req) begin
          w_state_d = ERR;
          w_err_d   = 1'b1;
        end
      end
      // The RAM samples at the end of ISSUE whether or not the master is still there.
      ISSUE: begin
        if (!wb.wb_cyc_i) begin
          w_state_d = IDLE;
        end else if (r_wr) begin
          w_state_d = ACK;
          w_ack_d   = 1'b1;
        end else begin
          w_state_d = RDATA;
        end
      end
      RDATA: begin
        if (!wb.wb_cyc_i) begin
          w_state_d = IDLE;
        end else begin
          w_state_d = ACK;
          w_ack_d   = 1'b1;
          w_dat_d   = ram_do_i;
        end
      end
      ACK:     w_state_d = IDLE;
      ERR:     w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_en      <= 1'b0;
      r_we_strb <= '0;
      r_a       <= '0;
      r_di      <= '0;
      r_dat     <= '0;
      r_wr      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ack     <= w_ack_d;
      r_err     <= w_err_d;
      r_en      <= w_en_d;
      r_we_strb <= w_we_strb_d;
      r_a       <= w_a_d;
      r_di      <= w_di_d;
      r_dat     <= w_dat_d;
      r_wr      <= w_wr_d;
    end
  end

  assign wb.wb_dat_o = r_dat;
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign ram_en_o    = r_en;
  assign ram_we_o    = r_we_strb;
  assign ram_a_o     = r_a;
  assign ram_di_o    = r_di;

endmodule
